// File: rtl/decode_pfx_pkg.sv
// Shared constants for the x86 legacy prefix front end.
package decode_pfx_pkg;

  // Legacy prefix byte values
  localparam logic [7:0] PFX_ES    = 8'h26;
  localparam logic [7:0] PFX_CS    = 8'h2E;
  localparam logic [7:0] PFX_SS    = 8'h36;
  localparam logic [7:0] PFX_DS    = 8'h3E;
  localparam logic [7:0] PFX_FS    = 8'h64;
  localparam logic [7:0] PFX_GS    = 8'h65;
  localparam logic [7:0] PFX_OPSZ  = 8'h66;
  localparam logic [7:0] PFX_ADSZ  = 8'h67;
  localparam logic [7:0] PFX_LOCK  = 8'hF0;
  localparam logic [7:0] PFX_REPNE = 8'hF2;
  localparam logic [7:0] PFX_REP   = 8'hF3;

  // Segment register codes
  localparam logic [2:0] SEG_ES = 3'd0;
  localparam logic [2:0] SEG_CS = 3'd1;
  localparam logic [2:0] SEG_SS = 3'd2;
  localparam logic [2:0] SEG_DS = 3'd3;
  localparam logic [2:0] SEG_FS = 3'd4;
  localparam logic [2:0] SEG_GS = 3'd5;

  // REP encodings
  localparam logic [1:0] REP_NONE = 2'b00;
  localparam logic [1:0] REP_NE   = 2'b10;
  localparam logic [1:0] REP_E    = 2'b11;

  // Sequencer states
  typedef enum logic {
    S_SCAN = 1'b0,
    S_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/prefix_byte_classify.sv
// Combinational byte-to-prefix-class decode.
module prefix_byte_classify
  import decode_pfx_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_seg,
  output logic [2:0] o_seg,
  output logic       o_is_opsz,
  output logic       o_is_lock,
  output logic       o_is_rep,
  output logic [1:0] o_rep,
  output logic       o_is_adsz,
  output logic       o_is_opcode
);

  // Classify one byte; anything not a known prefix is an opcode byte
  always_comb begin
    o_is_seg    = 1'b0;
    o_seg       = SEG_ES;
    o_is_opsz   = 1'b0;
    o_is_lock   = 1'b0;
    o_is_rep    = 1'b0;
    o_rep       = REP_NONE;
    o_is_adsz   = 1'b0;
    o_is_opcode = 1'b0;
    case (i_byte)
      PFX_ES:    begin o_is_seg = 1'b1; o_seg = SEG_ES; end
      PFX_CS:    begin o_is_seg = 1'b1; o_seg = SEG_CS; end
      PFX_SS:    begin o_is_seg = 1'b1; o_seg = SEG_SS; end
      PFX_DS:    begin o_is_seg = 1'b1; o_seg = SEG_DS; end
      PFX_FS:    begin o_is_seg = 1'b1; o_seg = SEG_FS; end
      PFX_GS:    begin o_is_seg = 1'b1; o_seg = SEG_GS; end
      PFX_OPSZ:  o_is_opsz = 1'b1;
      PFX_ADSZ:  o_is_adsz = 1'b1;
      PFX_LOCK:  o_is_lock = 1'b1;
      PFX_REPNE: begin o_is_rep = 1'b1; o_rep = REP_NE; end
      PFX_REP:   begin o_is_rep = 1'b1; o_rep = REP_E; end
      default:   o_is_opcode = 1'b1;
    endcase
  end

endmodule

// File: rtl/prefix_sequencer.sv
// Serial prefix stripper: accumulates legacy prefix state and hands the
// opcode byte plus prefix packet downstream over valid/ready.
module prefix_sequencer
  import decode_pfx_pkg::*;
#(
  parameter int MAX_PFX = 4,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_opcode,
  output logic             out_seg_vld,
  output logic [2:0]       out_seg,
  output logic             out_opsize,
  output logic             out_lock,
  output logic [1:0]       out_rep,
  output logic [CNT_W-1:0] out_pfx_cnt,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PFX);

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_opcode, w_opcode_nxt;
  logic             r_seg_vld, w_seg_vld_nxt;
  logic [2:0]       r_seg, w_seg_nxt;
  logic             r_opsize, w_opsize_nxt;
  logic             r_lock, w_lock_nxt;
  logic [1:0]       r_rep, w_rep_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_err, w_err_nxt;

  logic       w_is_seg, w_is_opsz, w_is_lock, w_is_rep, w_is_adsz, w_is_opcode;
  logic [2:0] w_seg_code;
  logic [1:0] w_rep_code;

  prefix_byte_classify u_classify (
    .i_byte      (in_byte),
    .o_is_seg    (w_is_seg),
    .o_seg       (w_seg_code),
    .o_is_opsz   (w_is_opsz),
    .o_is_lock   (w_is_lock),
    .o_is_rep    (w_is_rep),
    .o_rep       (w_rep_code),
    .o_is_adsz   (w_is_adsz),
    .o_is_opcode (w_is_opcode)
  );

  assign in_ready    = (r_state == S_SCAN) && !flush;
  assign out_valid   = (r_state == S_HOLD);
  assign out_opcode  = r_opcode;
  assign out_seg_vld = r_seg_vld;
  assign out_seg     = r_seg;
  assign out_opsize  = r_opsize;
  assign out_lock    = r_lock;
  assign out_rep     = r_rep;
  assign out_pfx_cnt = r_cnt;
  assign out_err     = r_err;

  // Next-state and accumulator update; flush outranks a handoff in HOLD
  always_comb begin
    w_state_nxt   = r_state;
    w_opcode_nxt  = r_opcode;
    w_seg_vld_nxt = r_seg_vld;
    w_seg_nxt     = r_seg;
    w_opsize_nxt  = r_opsize;
    w_lock_nxt    = r_lock;
    w_rep_nxt     = r_rep;
    w_cnt_nxt     = r_cnt;
    w_err_nxt     = r_err;
    if (flush || (r_state == S_HOLD && out_ready)) begin
      w_state_nxt   = S_SCAN;
      w_opcode_nxt  = '0;
      w_seg_vld_nxt = 1'b0;
      w_seg_nxt     = '0;
      w_opsize_nxt  = 1'b0;
      w_lock_nxt    = 1'b0;
      w_rep_nxt     = REP_NONE;
      w_cnt_nxt     = '0;
      w_err_nxt     = 1'b0;
    end else if (r_state == S_SCAN && in_valid) begin
      if (w_is_adsz) begin
        // 0x67 always counts, so the count may reach MAX_PFX+1 here
        w_err_nxt    = 1'b1;
        w_opcode_nxt = in_byte;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_state_nxt  = S_HOLD;
      end else if (w_is_opcode) begin
        w_opcode_nxt = in_byte;
        w_state_nxt  = S_HOLD;
      end else if (r_cnt == MAX_C) begin
        w_err_nxt    = 1'b1;
        w_opcode_nxt = in_byte;
        w_state_nxt  = S_HOLD;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_is_seg) begin
          w_seg_vld_nxt = 1'b1;
          w_seg_nxt     = w_seg_code;
        end
        if (w_is_opsz) w_opsize_nxt = 1'b1;
        if (w_is_lock) w_lock_nxt   = 1'b1;
        if (w_is_rep)  w_rep_nxt    = w_rep_code;
      end
    end
  end

  // State and packet registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_SCAN;
      r_opcode  <= '0;
      r_seg_vld <= 1'b0;
      r_seg     <= '0;
      r_opsize  <= 1'b0;
      r_lock    <= 1'b0;
      r_rep     <= REP_NONE;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_opcode  <= w_opcode_nxt;
      r_seg_vld <= w_seg_vld_nxt;
      r_seg     <= w_seg_nxt;
      r_opsize  <= w_opsize_nxt;
      r_lock    <= w_lock_nxt;
      r_rep     <= w_rep_nxt;
      r_cnt     <= w_cnt_nxt;
      r_err     <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_prefix_sequencer.sv
// Self-checking bench for prefix_sequencer.
module tb_prefix_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_opcode;
  logic       out_seg_vld;
  logic [2:0] out_seg;
  logic       out_opsize;
  logic       out_lock;
  logic [1:0] out_rep;
  logic [2:0] out_pfx_cnt;
  logic       out_err;

  int total = 0;
  int bad   = 0;

  logic [19:0] exp_q[$];

  typedef struct {
    logic [63:0] bytes;   // first byte in the most significant used lane
    int          n;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[10];

  prefix_sequencer #(.MAX_PFX(4), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_byte     (in_byte),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_seg_vld (out_seg_vld),
    .out_seg     (out_seg),
    .out_opsize  (out_opsize),
    .out_lock    (out_lock),
    .out_rep     (out_rep),
    .out_pfx_cnt (out_pfx_cnt),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] pk(input logic [7:0] opc, input logic segv,
                                     input logic [2:0] seg, input logic opsz,
                                     input logic lock, input logic [1:0] rep,
                                     input logic [2:0] cnt, input logic err);
    return {opc, segv, seg, opsz, lock, rep, cnt, err};
  endfunction

  function automatic logic [19:0] act_pkt();
    return {out_opcode, out_seg_vld, out_seg, out_opsize, out_lock, out_rep,
            out_pfx_cnt, out_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each transferred packet against the queue head
  always @(negedge clk) begin
    if (reset && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) chk("pkt_unexpected", exp_q.size(), 1);
      else chk($sformatf("pkt@%0t", $time), act_pkt(), exp_q.pop_front());
    end
  end

  // Present one byte and hold it until accepted (bounded); ends at edge+1
  task automatic send(input logic [7:0] b);
    int k = 0;
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // After the opcode byte with out_ready=1: one-cycle valid pulse then idle
  task automatic handoff(input string name);
    @(negedge clk);
    chk({name, "_valid_hi"}, out_valid, 1);
    chk({name, "_ready_lo"}, in_ready, 0);
    @(negedge clk);
    chk({name, "_valid_lo"}, out_valid, 0);
    chk({name, "_ready_hi"}, in_ready, 1);
    chk({name, "_drained"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{64'h2E668B,     3, pk(8'h8B, 1, 3'd1, 1, 0, 2'b00, 3'd2, 0)};
    vecs[1] = '{64'h2664F2F3A5, 5, pk(8'hA5, 1, 3'd4, 0, 0, 2'b11, 3'd4, 0)};
    vecs[2] = '{64'h6666666666, 5, pk(8'h66, 0, 3'd0, 1, 0, 2'b00, 3'd4, 1)};
    vecs[3] = '{64'hF090,       2, pk(8'h90, 0, 3'd0, 0, 1, 2'b00, 3'd1, 0)};
    vecs[4] = '{64'h6567,       2, pk(8'h67, 1, 3'd5, 0, 0, 2'b00, 3'd2, 1)};
    vecs[5] = '{64'hF20F,       2, pk(8'h0F, 0, 3'd0, 0, 0, 2'b10, 3'd1, 0)};
    vecs[6] = '{64'h90,         1, pk(8'h90, 0, 3'd0, 0, 0, 2'b00, 3'd0, 0)};
    vecs[7] = '{64'h36263EF067, 5, pk(8'h67, 1, 3'd3, 0, 1, 2'b00, 3'd5, 1)};
    vecs[8] = '{64'hF3F3F3F3C3, 5, pk(8'hC3, 0, 3'd0, 0, 0, 2'b11, 3'd4, 0)};
    vecs[9] = '{64'h26F0F26665, 5, pk(8'h65, 1, 3'd0, 1, 1, 2'b10, 3'd4, 1)};

    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b1;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_pkt", act_pkt(), 0);
    #10 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Table-driven instructions with out_ready held high
    for (int v = 0; v < 10; v++) begin
      logic [63:0] bs;
      bs = vecs[v].bytes;
      exp_q.push_back(vecs[v].exp);
      for (int i = 0; i < vecs[v].n; i++)
        send(bs[8*(vecs[v].n-1-i) +: 8]);
      handoff($sformatf("vec%0d", v));
    end

    // Backpressure: packet and in_ready stable for 5 cycles
    out_ready = 1'b0;
    exp_q.push_back(pk(8'hAB, 1, 3'd3, 0, 0, 2'b11, 3'd2, 0));
    send(8'h3E); send(8'hF3); send(8'hAB);
    in_valid = 1'b1;
    in_byte  = 8'h55;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", c), out_valid, 1);
      chk($sformatf("hold%0d_ready", c), in_ready, 0);
      chk($sformatf("hold%0d_pkt", c), act_pkt(), pk(8'hAB, 1, 3'd3, 0, 0, 2'b11, 3'd2, 0));
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_rel_ready", in_ready, 1);
    chk("hold_rel_valid", out_valid, 0);
    chk("hold_rel_pkt", act_pkt(), 0);
    chk("hold_drained", exp_q.size(), 0);
    @(posedge clk); #1;

    // Flush during SCAN clears accumulators and refuses the byte
    send(8'h3E); send(8'hF0);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h90;
    @(negedge clk);
    chk("flush_ready", in_ready, 0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_pkt", act_pkt(), 0);
    chk("flush_valid", out_valid, 0);
    @(posedge clk); #1;
    exp_q.push_back(pk(8'h90, 0, 3'd0, 0, 0, 2'b00, 3'd0, 0));
    send(8'h90);
    handoff("post_flush");

    // Flush and out_ready together in HOLD: packet dropped
    out_ready = 1'b0;
    send(8'hC3);
    @(negedge clk);
    chk("fh_valid", out_valid, 1);
    @(posedge clk); #1;
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fh_valid_lo", out_valid, 0);
    chk("fh_pkt", act_pkt(), 0);
    chk("fh_ready", in_ready, 1);
    @(posedge clk); #1;

    // Asynchronous reset mid-cycle while holding a packet
    out_ready = 1'b0;
    send(8'h8B);
    @(negedge clk);
    chk("ar_valid_pre", out_valid, 1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_pkt", act_pkt(), 0);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    chk("ar_ready", in_ready, 1);
    out_ready = 1'b1;
    exp_q.push_back(pk(8'h67, 0, 3'd0, 0, 0, 2'b00, 3'd1, 1));
    send(8'h67);
    handoff("ar_67");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
